// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB first, with a start/done handshake.
// Results are published only on the final bit, so partial sums never reach the outputs.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-2:0] d_sr_q;
    logic             borrow_q;
    logic [CntW-1:0]  cnt_q;

    logic             x;
    logic             y;
    logic             d;
    logic             borrow_d;
    logic [WIDTH-1:0] res;

    always_comb begin
        x        = a_sr_q[0];
        y        = b_sr_q[0];
        d        = x ^ y ^ borrow_q;
        borrow_d = (~x & y) | (~x & borrow_q) | (y & borrow_q);
        // Difference bits enter at the MSB; after WIDTH shifts the LSB sits at bit 0.
        res      = {d, d_sr_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.zero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_sr_q   <= bus.a;
                        b_sr_q   <= bus.b;
                        d_sr_q   <= '0;
                        borrow_q <= bus.bin;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    d_sr_q   <= res[WIDTH-1:1];
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        bus.diff <= res;
                        bus.bout <= borrow_d;
                        bus.zero <= (res == '0);
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    bus.done <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end
endmodule
